arbitro_memoria: RTL
====================

Name: arbitro_memoria

Overview:
Sequences and shares the single word-wide memory port between the instruction-fetch requester and the load/store data requester of the multicycle CPU. It owns the memory read/write wait states, so the control FSM only issues a request and waits for an acknowledge. It sits between the control unit/datapath address muxing and the memory instance, and drives the memory write/read strobe, address and write data.

Parameters:
READ_LAT, 2, memory read latency in cycles (>=1); data is sampled from mem_rdata on the last access cycle.
WRITE_LAT, 1, cycles mem_wr is held high per write (>=1).
ADDR_W, 32, address width.
DATA_W, 32, data width.

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, read only
if_addr  in  ADDR_W  fetch byte address
if_ack  out  1  one-cycle fetch completion pulse
if_err  out  1  fetch misaligned, valid with if_ack
if_rdata  out  DATA_W  fetched word, valid with if_ack
d_req  in  1  data request
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle data completion pulse
d_err  out  1  data misaligned, valid with d_ack
d_rdata  out  DATA_W  load data, valid with d_ack
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wr  out  1  1=write, 0=read
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in any state other than IDLE
estado  out  2  current state encoding, for debug

Behaviour:
- Reset (reset=0, asynchronous) puts the FSM in IDLE and clears all outputs: mem_addr, mem_wdata, mem_wr, acks, errs, rdata, busy and estado are all 0. last_owner is set to DATA, so fetch wins the first contention.
- States: IDLE=0, ACCESS=1, RESP=2.
- IDLE: mem_wr=0.
  - If no request is pending, stay in IDLE.
  - If only one request is pending, grant it.
  - If both are pending, grant the requester that is not last_owner (round-robin).
  - On the grant edge, latch owner, addr, we (fetch: we=0) and wdata, and update last_owner.
  - If latched addr[1:0]!=0, go to RESP with err=1, rdata=0 and no memory access.
  - Otherwise go to ACCESS and load cnt = (we ? WRITE_LAT : READ_LAT) - 1.
- ACCESS: mem_addr=latched addr, mem_wdata=latched wdata, mem_wr=latched we.
  - If cnt!=0, decrement cnt.
  - If cnt==0: for a read, capture mem_rdata into the owner's rdata register; then go to RESP.
- RESP: mem_wr=0 and mem_addr holds its value. Pulse the owner's ack for exactly one cycle; err is valid in the same cycle. Go to IDLE.
- Latency from the grant edge to the ack cycle:
  - read: READ_LAT+1 cycles
  - write: WRITE_LAT+1 cycles
  - misaligned: 1 cycle
  - Idle-to-idle throughput: one access per (LAT+2) cycles.
- Handshake rules:
  - req and its payload are sampled only in IDLE. Changes after the grant are ignored.
  - A requester deasserts req on the edge that ends its ack cycle. A req still high in the following IDLE cycle is a new request.
  - The ungranted requester simply keeps req high and is not lost.
- rdata registers hold their value until that owner's next read completes. Stores do not modify d_rdata.
- Counter width is $clog2(max(READ_LAT,WRITE_LAT)+1). cnt saturates at 0 and never wraps.
- Reset mid-ACCESS: mem_wr drops immediately (asynchronously), no ack is issued, the FSM returns to IDLE, and the request is lost.
- Simultaneous ack for both requesters is impossible. The implementation asserts that if_ack & d_ack is never 1.

Decomposition:
- Shared package pkg_arbitro:
  - state enum (IDLE, ACCESS, RESP)
  - owner constants OWNER_IF=0, OWNER_D=1
  - alignment mask constant
- One sub-module, contador_espera (loadable down-counter with zero flag), is natural. Everything else is inline.

Test Plan:
- Reset: hold reset=0 for 3 cycles with both req=1. Required: all outputs 0, mem_wr=0, busy=0, no ack.
- Fetch read, READ_LAT=2: if_addr=0x4, memory returns 0x8C020004. Required: mem_addr=0x4 and mem_wr=0 for 2 cycles, then if_ack=1 with if_rdata=0x8C020004 exactly 3 cycles after the grant edge, if_err=0.
- Store, WRITE_LAT=1: d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF. Required: mem_wr=1 for exactly 1 cycle with mem_addr=0x10 and mem_wdata=0xDEADBEEF, d_ack next cycle, d_rdata unchanged.
- Contention after reset: if_req and d_req both held. Required: fetch is served first, data second. Repeating the contention alternates the owner, and each ack appears once per service.
- Misaligned load: d_addr=0x6. Required: d_ack=1 and d_err=1 one cycle after the grant, d_rdata=0, mem_wr never asserted, busy high for 1 cycle.
- Reset during write with WRITE_LAT=3: drop reset in the 2nd ACCESS cycle. Required: mem_wr falls immediately, no d_ack, estado=IDLE, and the next request is served normally.

Source files
------------

// File: rtl/arbitro_memoria_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM encoding,
// requester identities and the word-alignment check.
package pkg_arbitro;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } estado_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic desalineado(input logic [1:0] addr_lo);
    return |(addr_lo & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/arbitro_memoria_contador.sv
// Loadable down-counter that tracks the remaining wait-state cycles of a
// memory access; it stops at zero instead of wrapping.
module contador_espera #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/arbitro_memoria.sv
// Shares the single memory port between instruction fetch and load/store,
// owning the read/write wait states and answering each requester with an ack.
module arbitro_memoria
  import pkg_arbitro::*;
#(
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        estado
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

  // Valid/ready: a requester raises req with a stable payload and keeps it
  // until granted; req and payload are only sampled while IDLE, and a req
  // still high in the IDLE cycle after its ack is taken as a new request.

  estado_t           state_q;
  logic              owner_q;
  logic              last_owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_wr_q;
  logic              if_ack_q, d_ack_q;
  logic              if_err_q, d_err_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic              gnt_valid;
  logic              gnt_owner;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_we;
  logic              gnt_mis;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_dec;
  logic              cnt_zero;

  // Round-robin: on contention the requester that was not served last wins.
  always_comb begin
    gnt_valid = if_req | d_req;
    gnt_owner = OWNER_IF;
    if (if_req && d_req) begin
      gnt_owner = (last_owner_q == OWNER_IF) ? OWNER_D : OWNER_IF;
    end else if (d_req) begin
      gnt_owner = OWNER_D;
    end
    gnt_addr = (gnt_owner == OWNER_D) ? d_addr : if_addr;
    gnt_we   = (gnt_owner == OWNER_D) && d_we;
    gnt_mis  = desalineado(gnt_addr[1:0]);
  end

  assign cnt_load     = (state_q == S_IDLE) && gnt_valid && !gnt_mis;
  assign cnt_load_val = gnt_we ? WR_LOAD : RD_LOAD;
  assign cnt_dec      = (state_q == S_ACCESS);

  contador_espera #(
    .W (CNT_W)
  ) u_contador (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWNER_IF;
      last_owner_q <= OWNER_D;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_q     <= 1'b0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_err_q     <= 1'b0;
      d_err_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      if_err_q <= 1'b0;
      d_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          mem_wr_q <= 1'b0;
          if (gnt_valid) begin
            owner_q      <= gnt_owner;
            last_owner_q <= gnt_owner;
            we_q         <= gnt_we;
            if (gnt_mis) begin
              // Misaligned: answer with an error, memory is never touched.
              state_q <= S_RESP;
              if (gnt_owner == OWNER_D) begin
                d_ack_q <= 1'b1;
                d_err_q <= 1'b1;
                if (!gnt_we) d_rdata_q <= '0;
              end else begin
                if_ack_q   <= 1'b1;
                if_err_q   <= 1'b1;
                if_rdata_q <= '0;
              end
            end else begin
              state_q     <= S_ACCESS;
              mem_addr_q  <= gnt_addr;
              mem_wdata_q <= (gnt_owner == OWNER_D) ? d_wdata : '0;
              mem_wr_q    <= gnt_we;
            end
          end
        end
        S_ACCESS: begin
          if (cnt_zero) begin
            state_q  <= S_RESP;
            mem_wr_q <= 1'b0;
            if (owner_q == OWNER_D) begin
              d_ack_q <= 1'b1;
              if (!we_q) d_rdata_q <= mem_rdata;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          mem_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = (state_q != S_IDLE);
  assign estado    = state_q;

  ack_exclusivo: assert property (@(posedge clk) disable iff (!reset) !(if_ack && d_ack));

endmodule
